// File: rtl/id_ex_stage.sv
// ID operand stage: regfile read addressing, WB->ID bypass, XZR zeroing, load-use stall, ID/EX register.
// Optional build macro ID_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module id_ex_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned ZR_IDX = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [31:0]       id_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg2loc,
    input  logic              id_memread,
    input  logic              id_regwrite,
    input  logic              id_uses_b,
    output logic [4:0]        ra1,
    output logic [4:0]        ra2,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_wa,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [31:0]       ex_instr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [4:0]        ex_rd,
    output logic              ex_memread,
`ifdef ID_STALL_CNT_EN
    output logic              ex_regwrite,
    output logic [31:0]       stall_cnt
`else
    output logic              ex_regwrite
`endif
);

    localparam logic [4:0] ZR = 5'(ZR_IDX);

    logic [XLEN-1:0]   op_a, op_b;
    logic              haz;

    logic              ex_valid_q, ex_valid_d;
    logic              ex_memread_q, ex_memread_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [31:0]       ex_instr_q, ex_instr_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0]   ex_a_q, ex_a_d;
    logic [XLEN-1:0]   ex_b_q, ex_b_d;
    logic [4:0]        ex_rd_q, ex_rd_d;

    assign ra1 = id_instr[9:5];
    assign ra2 = id_reg2loc ? id_instr[4:0] : id_instr[20:16];

    // Zero register wins over bypass so a WB to X31 can never leak a value
    always_comb begin
        op_a = rd1;
        op_b = rd2;
        if (ra1 == ZR)                           op_a = '0;
        else if (wb_regwrite && (wb_wa == ra1))  op_a = wb_wd;
        if (ra2 == ZR)                           op_b = '0;
        else if (wb_regwrite && (wb_wa == ra2))  op_b = wb_wd;
    end

    assign haz = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != ZR) &&
                 ((ex_rd_q == ra1) || (id_uses_b && (ex_rd_q == ra2)));
    assign stall = haz && !flush;

    // Bubbles clear only the qualifying bits; data fields hold their last values
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_memread_d  = ex_memread_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_pc_d       = ex_pc_q;
        ex_instr_d    = ex_instr_q;
        ex_ctrl_d     = ex_ctrl_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_rd_d       = ex_rd_q;
        if (flush || haz) begin
            ex_valid_d    = 1'b0;
            ex_memread_d  = 1'b0;
            ex_regwrite_d = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_memread_d  = id_memread && id_valid;
            ex_regwrite_d = id_regwrite && id_valid;
            ex_pc_d       = id_pc;
            ex_instr_d    = id_instr;
            ex_ctrl_d     = id_ctrl;
            ex_a_d        = op_a;
            ex_b_d        = op_b;
            ex_rd_d       = id_instr[4:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_pc_q       <= '0;
            ex_instr_q    <= '0;
            ex_ctrl_q     <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_rd_q       <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_memread_q  <= ex_memread_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_pc_q       <= ex_pc_d;
            ex_instr_q    <= ex_instr_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_rd_q       <= ex_rd_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_memread  = ex_memread_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_pc       = ex_pc_q;
    assign ex_instr    = ex_instr_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_rd       = ex_rd_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled edges; flush-masked hazards are not stalls
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
